adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit; the successor to the single-cycle 64-bit ripple adder. Splits a WIDTH-bit operation into STAGES equal carry-chained slices, one slice per clock, with a valid/ready handshake on both sides and optional ARM-style NZCV flag generation. Used wherever a long carry chain would limit the CPU clock: address generation, multi-cycle ALU paths and the branch-target adder.

---
 rtl/adder_pipe.sv | 133 +++++++++++++
 tb/tb_adder_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit add/subtract, one SW-bit carry-chained slice
// per stage, valid/ready on both sides, whole-pipe stall on output back-pressure.
// Optional NZCV flag generation is enabled by defining ADDER_PIPE_FLAGS_EN;
// without it the flags port is tied to zero and no flag logic is built.
module adder_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // One global advance: the pipe moves as a unit or holds as a unit.
    logic adv;

    // Per-stage combinational inputs and results.
    logic [WIDTH-1:0] a_in     [STAGES];
    logic [WIDTH-1:0] b_in     [STAGES];
    logic [WIDTH-1:0] s_in     [STAGES];
    logic             c_in     [STAGES];
    logic             v_in     [STAGES];
    logic [SW:0]      slice_sum[STAGES];
    logic [WIDTH-1:0] s_next   [STAGES];
    logic             c_next   [STAGES];

    // Per-stage registers: skewed operands (B already conditionally inverted),
    // partial result, slice carry and valid.
    logic [WIDTH-1:0] a_q[STAGES];
    logic [WIDTH-1:0] b_q[STAGES];
    logic [WIDTH-1:0] s_q[STAGES];
    logic             c_q[STAGES];
    logic             v_q[STAGES];

    assign adv       = !v_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign out       = s_q[LAST];

    // Slice adders: stage k adds slice k of its operands plus the carry from stage k-1.
    always_comb begin
        // Stage 0 takes the operation straight from the ports; the subtract
        // bit becomes both the B inversion and the initial carry.
        a_in[0] = A;
        b_in[0] = sub ? ~B : B;
        s_in[0] = '0;
        c_in[0] = sub;
        v_in[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_in[k][k*SW +: SW]}
                         + {1'b0, b_in[k][k*SW +: SW]}
                         + {{SW{1'b0}}, c_in[k]};
            s_next[k]    = s_in[k];
            s_next[k][k*SW +: SW] = slice_sum[k][SW-1:0];
            c_next[k]    = slice_sum[k][SW];
        end
    end

    // Pipeline registers: cleared on reset, advanced together on adv; data
    // only loads behind a valid operation so bubbles leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_next[k];
                    c_q[k] <= c_next[k];
                end
            end
        end
    end

`ifdef ADDER_PIPE_FLAGS_EN
    logic [3:0]       flags_q;
    logic [3:0]       flags_next;
    logic [WIDTH-1:0] final_res;
    logic             a_msb;
    logic             b_msb;

    // NZCV of the completed result; operand sign bits arrive with the MSB slice.
    always_comb begin
        final_res  = s_next[LAST];
        a_msb      = a_in[LAST][WIDTH-1];
        b_msb      = b_in[LAST][WIDTH-1];
        flags_next = {final_res[WIDTH-1],
                      final_res == '0,
                      c_next[LAST],
                      (a_msb == b_msb) && (final_res[WIDTH-1] != a_msb)};
    end

    // Flag register loads alongside the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (adv && v_in[LAST]) begin
            flags_q <= flags_next;
        end
    end

    assign flags = flags_q;
`else
    assign flags = '0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed vector table, random streaming with back-pressure
// against an arithmetic reference model, and mid-flight reset.
module tb_adder_pipe;

    localparam int W  = 64;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t        vecs[8];
    logic [67:0] exp_q[$];

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flag_exp(input logic [3:0] f);
`ifdef ADDER_PIPE_FLAGS_EN
        return f;
`else
        return 4'b0000 & f;
`endif
    endfunction

    // Reference: plain unsigned/signed arithmetic, ARM carry convention.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0]        res;
        logic               c;
        logic               v;
        logic signed [65:0] e;
        res = s ? a - b : a + b;
        c   = s ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF);
        e   = s ? ($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}))
                : ($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
        v   = (e != {{2{e[63]}}, e[63:0]});
        return {res, flag_exp({res[63], res == 64'd0, c, v})};
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(7))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic one_op(input logic [63:0] a, input logic [63:0] b, input logic s, output int lat);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        sub       = s;
        out_ready = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_stream(input int nops, input int pv, input int pr,
                              output int first_cyc, output int last_cyc);
        int          sent = 0;
        int          cyc  = 0;
        logic        held = 1'b0;
        logic [63:0] hout = '0;
        logic [3:0]  hflags = '0;
        logic [67:0] e;
        first_cyc = -1;
        last_cyc  = -1;
        while ((sent < nops || exp_q.size() > 0) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                check("stall_valid", {67'd0, out_valid}, 68'd1);
                check("stall_hold", {out, flags}, {hout, hflags});
            end
            in_valid  = (sent < nops) && ($urandom_range(99) < pv);
            A         = rand64();
            B         = rand64();
            sub       = 1'($urandom_range(1));
            out_ready = ($urandom_range(99) < pr);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {out, flags}, 68'hx);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", {out, flags}, e);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            held   = out_valid && !out_ready;
            hout   = out;
            hflags = flags;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, sub));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 3000) check("stream_timeout", 68'd1, 68'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int f;
        int l;

        vecs[0] = '{a: 64'd456, b: 64'd1200, s: 1'b0, exp_out: 64'd1656, exp_flags: 4'b0000};
        vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, s: 1'b0, exp_out: 64'h0, exp_flags: 4'b0110};
        vecs[2] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, s: 1'b0,
                    exp_out: 64'h8000_0000_0000_0000, exp_flags: 4'b1001};
        vecs[3] = '{a: 64'd5, b: 64'd7, s: 1'b1, exp_out: 64'hFFFF_FFFF_FFFF_FFFE, exp_flags: 4'b1000};
        vecs[4] = '{a: 64'd7, b: 64'd5, s: 1'b1, exp_out: 64'd2, exp_flags: 4'b0010};
        vecs[5] = '{a: 64'd0, b: 64'd0, s: 1'b1, exp_out: 64'd0, exp_flags: 4'b0110};
        vecs[6] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, s: 1'b1,
                    exp_out: 64'h7FFF_FFFF_FFFF_FFFF, exp_flags: 4'b0011};
        vecs[7] = '{a: 64'h0000_0000_FFFF_FFFF, b: 64'd1, s: 1'b0,
                    exp_out: 64'h0000_0001_0000_0000, exp_flags: 4'b0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_out_valid", {67'd0, out_valid}, 68'd0);
        check("reset_out", {4'd0, out}, 68'd0);
        check("reset_flags", {64'd0, flags}, 68'd0);
        check("reset_in_ready", {67'd0, in_ready}, 68'd1);

        for (int i = 0; i < 8; i++) begin
            one_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            check($sformatf("vec%0d_latency", i), 68'(lat), 68'(ST));
            check($sformatf("vec%0d_out", i), {4'd0, out}, {4'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_flags", i), {64'd0, flags}, {64'd0, flag_exp(vecs[i].exp_flags)});
        end

        @(posedge clk); #1;
        exp_q.delete();
        run_stream(20, 100, 100, f, l);
        check("b2b_first_latency", 68'(f), 68'(ST + 1));
        check("b2b_consecutive", 68'(l - f), 68'd19);

        run_stream(300, 70, 60, f, l);

        // Three operations in flight, then a one-cycle reset.
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            A         = 64'(100 + i);
            B         = 64'd1;
            sub       = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_out_valid", {67'd0, out_valid}, 68'd0);
        check("midreset_out", {4'd0, out}, 68'd0);
        check("midreset_flags", {64'd0, flags}, 68'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("no_stale_%0d", i), {67'd0, out_valid}, 68'd0);
        end
        one_op(64'd1000, 64'd24, 1'b0, lat);
        check("post_reset_latency", 68'(lat), 68'(ST));
        check("post_reset_out", {out, flags}, model(64'd1000, 64'd24, 1'b0));

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
